// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised RS232 receiver with optional parity, start-bit
// glitch rejection, sticky error flags and a show-ahead receive FIFO.
// The line is sampled once per bit at the mid-bit tick. The FSM returns to
// IDLE at the stop-bit mid-sample, which lets it resync to back-to-back frames.
module uart_rx_fifo #(
  parameter int FREQ_HZ    = 25_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          RxD,
  input  logic                          fsel,
  input  logic                          done,
  input  logic                          clr_err,
  output logic                          rdy,
  output logic [7:0]                    data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          framing_err,
  output logic                          overrun
);

  localparam int          DIV      = FREQ_HZ / BAUD_RATE;
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_C    = 16'(DIV);
  localparam logic [1:0]  PAR_MODE = 2'(PARITY);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [AW:0] DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ZERO = (AW + 1)'(0);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  // Returns 1 when the received parity bit does not match the configured mode.
  // Bits of d above DATA_BITS are always zero, so they do not affect the result.
  function automatic logic parity_bad(input logic [7:0] d, input logic pbit,
                                      input logic [1:0] mode);
    logic ones_odd;
    ones_odd = ^{d, pbit};
    case (mode)
      2'd1:    parity_bad = ~ones_odd;
      2'd2:    parity_bad = ones_odd;
      default: parity_bad = 1'b0;
    endcase
  endfunction

  // Synchronizer
  logic s1_q, s2_q;

  // Receive FSM
  logic [2:0]  state_q, state_d;
  logic [15:0] tick_q, tick_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_bad_q, par_bad_d;

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rdy_q, rdy_d;
  logic [7:0]    data_q, data_d;

  // Sticky flags
  logic perr_q, perr_d;
  logic ferr_q, ferr_d;
  logic ovr_q, ovr_d;

  // Combinational helpers
  logic        fall_s, line_s;
  logic [15:0] period_s, half_s;
  logic        mid_s, last_tick_s;
  logic        push_s, push_perr_s, push_ferr_s;
  logic        full_s, pop_s, wr_en_s, drop_s;

  assign fall_s = s2_q & ~s1_q;
  assign line_s = s2_q;

  // Two-flop synchronizer on the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= RxD;
      s2_q <= s1_q;
    end
  end

  // Bit-period selection and the tick-counter compare points.
  always_comb begin
    if (fsel) begin
      period_s = {1'b0, DIV_C[15:1]};
    end else begin
      period_s = DIV_C;
    end
    half_s      = {1'b0, period_s[15:1]};
    mid_s       = (tick_q == half_s);
    last_tick_s = (tick_q == (period_s - 16'd1));
  end

  // Frame FSM: start qualification, LSB-first shift, parity check, stop push.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    par_bad_d   = par_bad_q;
    push_s      = 1'b0;
    push_perr_s = 1'b0;
    push_ferr_s = 1'b0;

    if (state_q == ST_IDLE) begin
      tick_d = 16'd0;
    end else if (last_tick_s) begin
      tick_d = 16'd0;
    end else begin
      tick_d = tick_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall_s) begin
          state_d   = ST_START;
          tick_d    = 16'd0;
          bitcnt_d  = 3'd0;
          shreg_d   = 8'h00;
          par_bad_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (mid_s) begin
          if (!line_s) begin
            state_d  = ST_DATA;
            bitcnt_d = 3'd0;
          end else begin
            // Line went back high before mid-bit: a glitch, not a start bit.
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (mid_s) begin
          shreg_d[bitcnt_q] = line_s;
          if (bitcnt_q == LAST_BIT) begin
            if (PAR_MODE != 2'd0) begin
              state_d = ST_PAR;
            end else begin
              state_d = ST_STOP;
            end
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PAR: begin
        if (mid_s) begin
          par_bad_d = parity_bad(shreg_q, line_s, PAR_MODE);
          state_d   = ST_STOP;
        end else begin
          state_d = ST_PAR;
        end
      end
      ST_STOP: begin
        if (mid_s) begin
          push_s      = 1'b1;
          push_perr_s = par_bad_q;
          push_ferr_s = ~line_s;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = 16'd0;
      end
    endcase
  end

  // FSM, tick counter and shift register state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tick_q    <= 16'd0;
      bitcnt_q  <= 3'd0;
      shreg_q   <= 8'h00;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      par_bad_q <= par_bad_d;
    end
  end

  // FIFO control: push/pop arbitration, pointers, occupancy and show-ahead head.
  always_comb begin
    full_s  = (count_q == DEPTH_C);
    pop_s   = done & rdy_q;
    wr_en_s = push_s & (~full_s | pop_s);
    drop_s  = push_s & full_s & ~pop_s;

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    rdy_d = (count_d != CNT_ZERO);

    // The head slot may be the one being written this cycle (push into an
    // empty FIFO, or pop of the last entry alongside a push); bypass it.
    if (count_d == CNT_ZERO) begin
      data_d = 8'h00;
    end else if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
      data_d = shreg_q;
    end else begin
      data_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage; a write only happens when the push is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= shreg_q;
    end
  end

  // FIFO pointers, occupancy and registered head outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= CNT_ZERO;
      rdy_q    <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
      data_q   <= data_d;
    end
  end

  // Sticky error flags: a set on the push cycle beats a simultaneous clear.
  always_comb begin
    if (push_s && push_perr_s) begin
      perr_d = 1'b1;
    end else if (clr_err) begin
      perr_d = 1'b0;
    end else begin
      perr_d = perr_q;
    end

    if (push_s && push_ferr_s) begin
      ferr_d = 1'b1;
    end else if (clr_err) begin
      ferr_d = 1'b0;
    end else begin
      ferr_d = ferr_q;
    end

    if (drop_s) begin
      ovr_d = 1'b1;
    end else if (clr_err) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Sticky error flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovr_q  <= ovr_d;
    end
  end

  assign rdy         = rdy_q;
  assign data        = data_q;
  assign count       = count_q;
  assign parity_err  = perr_q;
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: three receivers with different configurations
// (8N1 depth 4, 8E1 depth 16, 6O1 depth 2) against a queue-level model that
// predicts each push from the frame contents and the bit timing.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int DIV = 217;

  logic       clk = 1'b0;
  logic       rst;
  logic       fsel;
  logic       clr_err;
  logic [2:0] done;
  logic       rxd [3];

  logic [2:0] o_rdy, o_pe, o_fe, o_ov;
  logic [7:0] o_data [3];
  logic [2:0] cnt0;
  logic [4:0] cnt1;
  logic [1:0] cnt2;
  int         o_cnt [3];

  assign o_cnt[0] = int'(cnt0);
  assign o_cnt[1] = int'(cnt1);
  assign o_cnt[2] = int'(cnt2);

  // Per-receiver configuration
  int dbits [3] = '{8, 8, 6};
  int pmode [3] = '{0, 2, 1};
  int depth [3] = '{4, 16, 2};

  // Model state
  int         cyc;
  logic [7:0] mmem [3][16];
  int         mhead [3];
  int         msize [3];
  logic       mpe [3], mfe [3], mov [3];

  // Pending push, one per line (frames on one line never overlap)
  int         s_cyc [3];
  logic [7:0] s_byte [3];
  logic       s_pe [3], s_fe [3], s_val [3];

  int total = 0;
  int bad   = 0;
  int kp [3];
  int kc;
  int rp;

  always #5 clk = ~clk;

  uart_rx_fifo #(.FREQ_HZ(25_000_000), .BAUD_RATE(115_200), .DATA_BITS(8),
                 .PARITY(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .RxD(rxd[0]), .fsel(fsel), .done(done[0]),
    .clr_err(clr_err), .rdy(o_rdy[0]), .data(o_data[0]), .count(cnt0),
    .parity_err(o_pe[0]), .framing_err(o_fe[0]), .overrun(o_ov[0]));

  uart_rx_fifo #(.FREQ_HZ(25_000_000), .BAUD_RATE(115_200), .DATA_BITS(8),
                 .PARITY(2), .FIFO_DEPTH(16)) dut1 (
    .clk(clk), .rst(rst), .RxD(rxd[1]), .fsel(fsel), .done(done[1]),
    .clr_err(clr_err), .rdy(o_rdy[1]), .data(o_data[1]), .count(cnt1),
    .parity_err(o_pe[1]), .framing_err(o_fe[1]), .overrun(o_ov[1]));

  uart_rx_fifo #(.FREQ_HZ(25_000_000), .BAUD_RATE(115_200), .DATA_BITS(6),
                 .PARITY(1), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .RxD(rxd[2]), .fsel(fsel), .done(done[2]),
    .clr_err(clr_err), .rdy(o_rdy[2]), .data(o_data[2]), .count(cnt2),
    .parity_err(o_pe[2]), .framing_err(o_fe[2]), .overrun(o_ov[2]));

  task automatic check(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cyc %0d)", name, idx, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: FIFO of bytes with pop-before-push when full, sticky flags with set priority.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        msize[i] = 0;
        mhead[i] = 0;
        mpe[i]   = 1'b0;
        mfe[i]   = 1'b0;
        mov[i]   = 1'b0;
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 3; i++) begin
        bit pop, push, drop;
        pop  = done[i] && (msize[i] > 0);
        push = s_val[i] && (s_cyc[i] == cyc);
        drop = push && (msize[i] == depth[i]) && !pop;
        mov[i] = drop ? 1'b1 : (clr_err ? 1'b0 : mov[i]);
        mpe[i] = (push && s_pe[i]) ? 1'b1 : (clr_err ? 1'b0 : mpe[i]);
        mfe[i] = (push && s_fe[i]) ? 1'b1 : (clr_err ? 1'b0 : mfe[i]);
        if (pop) begin
          mhead[i] = (mhead[i] + 1) % depth[i];
          msize[i] = msize[i] - 1;
        end
        if (push && !drop) begin
          mmem[i][(mhead[i] + msize[i]) % depth[i]] = s_byte[i];
          msize[i] = msize[i] + 1;
        end
      end
    end
  end

  // Compare every output of every receiver against the model each cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check("rdy",         i, int'(o_rdy[i]),  (msize[i] > 0) ? 1 : 0);
      check("data",        i, int'(o_data[i]), (msize[i] > 0) ? int'(mmem[i][mhead[i]]) : 0);
      check("count",       i, o_cnt[i],        msize[i]);
      check("parity_err",  i, int'(o_pe[i]),   int'(mpe[i]));
      check("framing_err", i, int'(o_fe[i]),   int'(mfe[i]));
      check("overrun",     i, int'(o_ov[i]),   int'(mov[i]));
    end
  end

  // Send one frame on line idx; the model push is scheduled at the stop mid-sample.
  // Sync adds two cycles before the FSM sees the start edge, plus one for the push register.
  task automatic send(input int idx, input logic [7:0] d, input logic pbit, input logic stopb);
    int         p, n, ones;
    logic [10:0] bits;
    logic [7:0] dm;
    p  = fsel ? DIV / 2 : DIV;
    dm = d & 8'((1 << dbits[idx]) - 1);
    bits = 11'd0;
    for (int k = 0; k < dbits[idx]; k++) bits[1 + k] = dm[k];
    n = 1 + dbits[idx];
    if (pmode[idx] != 0) begin
      bits[n] = pbit;
      n++;
    end
    bits[n] = stopb;
    ones = $countones(dm) + int'(pbit);
    s_byte[idx] = dm;
    s_pe[idx]   = (pmode[idx] == 1) ? (ones % 2 == 0) : (pmode[idx] == 2) ? (ones % 2 == 1) : 1'b0;
    s_fe[idx]   = !stopb;
    s_cyc[idx]  = cyc + 3 + p / 2 + n * p;
    s_val[idx]  = 1'b1;
    for (int k = 0; k <= n; k++) begin
      rxd[idx] = bits[k];
      step(p);
    end
    rxd[idx] = 1'b1;
  endtask

  task automatic pop(input int idx);
    done[idx] = 1'b1;
    step(1);
    done[idx] = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fsel = 1'b0;
    clr_err = 1'b0;
    done = 3'b000;
    for (int i = 0; i < 3; i++) begin
      rxd[i]   = 1'b1;
      s_val[i] = 1'b0;
      s_cyc[i] = 0;
    end
    #1 rst = 1'b0;
    step(3);
    check("reset_rdy",   0, int'(o_rdy[0]), 0);
    check("reset_count", 1, o_cnt[1], 0);
    check("reset_data",  2, int'(o_data[2]), 0);
    rst = 1'b1;
    step(2);

    // 8N1 byte 0x55 at 217 cycles per bit
    send(0, 8'h55, 1'b0, 1'b1);
    step(2);
    check("pin_55_data",  0, int'(o_data[0]), 8'h55);
    check("pin_55_count", 0, o_cnt[0], 1);
    pop(0);
    step(1);
    check("pin_55_empty", 0, int'(o_rdy[0]), 0);

    // Even parity 0xA3 and odd-parity 6-bit 0x2B, both with correct parity bits
    fork
      send(1, 8'hA3, 1'b0, 1'b1);
      send(2, 8'h2B, 1'b1, 1'b1);
    join
    check("pin_a3_data", 1, int'(o_data[1]), 8'hA3);
    check("pin_a3_perr", 1, int'(o_pe[1]), 0);
    check("pin_2b_data", 2, int'(o_data[2]), 8'h2B);
    // Wrong parity bits: bytes still pushed, flags set
    fork
      send(1, 8'hA3, 1'b1, 1'b1);
      send(2, 8'hFF, 1'b0, 1'b1);
    join
    check("pin_a3_bad_perr",  1, int'(o_pe[1]), 1);
    check("pin_a3_bad_count", 1, o_cnt[1], 2);
    check("pin_3f_perr",      2, int'(o_pe[2]), 1);
    check("pin_3f_count",     2, o_cnt[2], 2);
    pulse_clr();
    check("pin_clr_perr", 1, int'(o_pe[1]), 0);
    pop(1); pop(1); pop(2);
    check("pin_3f_zext", 2, int'(o_data[2]), 8'h3F);
    pop(2);

    // Short low pulse: glitch, nothing pushed
    rxd[0] = 1'b0;
    step(50);
    rxd[0] = 1'b1;
    step(300);
    check("pin_glitch_count", 0, o_cnt[0], 0);

    // Overfill depth-4 FIFO
    send(0, 8'h11, 1'b0, 1'b1);
    send(0, 8'h22, 1'b0, 1'b1);
    send(0, 8'h33, 1'b0, 1'b1);
    send(0, 8'h44, 1'b0, 1'b1);
    send(0, 8'h55, 1'b0, 1'b1);
    check("pin_full_count", 0, o_cnt[0], 4);
    check("pin_full_ovr",   0, int'(o_ov[0]), 1);
    for (int k = 0; k < 4; k++) begin
      check("pin_drain", 0, int'(o_data[0]), 8'h11 * (k + 1));
      pop(0);
    end
    check("pin_drained", 0, o_cnt[0], 0);
    pulse_clr();

    // Stop bit low
    send(0, 8'h7E, 1'b0, 1'b0);
    step(2);
    check("pin_7e_data", 0, int'(o_data[0]), 8'h7E);
    check("pin_7e_ferr", 0, int'(o_fe[0]), 1);
    pop(0);

    // Back-to-back at double rate
    fsel = 1'b1;
    step(1);
    send(0, 8'h01, 1'b0, 1'b1);
    send(0, 8'h80, 1'b0, 1'b1);
    check("pin_b2b_first", 0, int'(o_data[0]), 8'h01);
    pop(0);
    check("pin_b2b_second", 0, int'(o_data[0]), 8'h80);
    fsel = 1'b0;
    step(1);

    // Reset in the middle of a data bit, with an entry and a flag pending
    rxd[0] = 1'b0;
    step(DIV);
    rxd[0] = 1'b1;
    step(2 * DIV);
    rxd[0] = 1'b0;
    step(100);
    #1;
    rst = 1'b0;
    rxd[0] = 1'b1;
    for (int i = 0; i < 3; i++) s_val[i] = 1'b0;
    step(4);
    check("pin_rst_rdy", 0, int'(o_rdy[0]), 0);
    rst = 1'b1;
    step(10);
    send(0, 8'h3C, 1'b0, 1'b1);
    check("pin_3c_count", 0, o_cnt[0], 1);
    check("pin_3c_data",  0, int'(o_data[0]), 8'h3C);
    check("pin_3c_ferr",  0, int'(o_fe[0]), 0);
    pop(0);

    // Randomized frames on all lines with random pops and clears
    for (int r = 0; r < 16; r++) begin
      fsel = 1'($urandom_range(0, 1));
      step(1);
      rp = fsel ? DIV / 2 : DIV;
      for (int i = 0; i < 3; i++) begin
        kp[i] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 11 * rp - 1));
      end
      kc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11 * rp - 1)) : -1;
      fork
        send(0, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
        send(1, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
        send(2, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
        begin
          for (int k = 0; k < 11 * rp; k++) begin
            done    = {k == kp[2], k == kp[1], k == kp[0]};
            clr_err = (k == kc);
            step(1);
          end
          done    = 3'b000;
          clr_err = 1'b0;
        end
      join
    end
    step(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised RS232 receiver, successor to the fixed 8N1 receiver. Supports configurable data width, optional parity, start-bit glitch rejection and sticky error flags. A show-ahead receive FIFO decouples the line from the CPU. Sits on the I/O bus beside the existing transmitter. Software pops one entry per `done` strobe.

Parameters:
- FREQ_HZ, 25_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, nominal line rate.
  - DIV = FREQ_HZ/BAUD_RATE (integer).
  - Requires 4 <= DIV < 65536.
- DATA_BITS, 8, data bits per frame, 5..8.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- FIFO_DEPTH, 16, receive FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- RxD  in  1  serial line, idle high, asynchronous.
- fsel  in  1  1 = double rate (bit period DIV/2), 0 = DIV. Change only when line is idle.
- done  in  1  pop strobe: head entry has been read.
- clr_err  in  1  clears sticky error flags.
- rdy  out  1  FIFO not empty.
- data  out  8  FIFO head byte; zero-extended above DATA_BITS.
- count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- parity_err  out  1  sticky: a parity mismatch was detected.
- framing_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; counters and FIFO pointers are cleared.
  - rdy=0, count=0, data=0, all error flags = 0.
  - Synchronizer flops are set to 1.
  - A frame in progress is discarded.
- Input sampling: RxD passes through a 2-flop synchronizer (s1, s2). A falling edge is s2=1 & s1=0.
- Bit period: P = fsel ? DIV/2 : DIV cycles.
  - Tick counter is 16 bits and counts 0..P-1.
  - Mid-bit sample point is tick == P/2 (floor).
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: on a falling edge, go to START with tick=0.
  - START: at mid-bit, if line is low, go to DATA with bitcnt=0. If line is high, treat as a glitch and return to IDLE; nothing is pushed.
  - DATA: at each mid-bit, shift in LSB-first. After DATA_BITS samples, go to PAR if PARITY≠0, otherwise go to STOP.
  - PAR: at mid-bit, compare against the computed parity. Odd mode expects the total count of ones (data + parity bit) to be odd; even mode expects it to be even. Then go to STOP.
  - STOP: at mid-bit, push the frame and go to IDLE. Returning to IDLE at mid-stop, rather than waiting for bit end, allows resync to back-to-back frames.
- Push:
  - A byte with a parity or framing error is still pushed; the error only sets its sticky flag.
  - Error flags set on the push cycle.
  - clr_err clears them; if set and clear occur in the same cycle, set wins.
- FIFO behaviour:
  - Show-ahead: data is valid whenever rdy=1. Latency from stop-bit mid-sample to rdy=1 is one cycle.
  - done while empty is ignored.
  - done & rdy pops; the next entry appears on data the following cycle.
  - Push while full and no pop: the new byte is dropped and overrun is set. FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both are performed, count is unchanged, no overrun.
  - Push and pop in the same cycle while empty: not possible (push makes rdy one cycle later).
  - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Idle line: a line held low (break) produces one frame with framing_err=1. No new frame starts until a high→low edge is seen again.

Test Plan:
- Defaults, DIV=217. Send 8N1 frame 0x55 at 217 cycles/bit → rdy=1 one cycle after the stop mid-sample, data=0x55, count=1, no errors. Pulse done → rdy=0, count=0.
- PARITY=2. Send 0xA3 with parity bit 0 → data=0xA3, parity_err=0. Send 0xA3 with parity bit 1 → byte pushed, parity_err=1. Pulse clr_err → parity_err=0.
- RxD low for 50 cycles, then high → FSM returns to IDLE, count stays 0, no flags set.
- FIFO_DEPTH=4. Send 0x11, 0x22, 0x33, 0x44, 0x55 with no pops → count=4, overrun=1, data=0x11. Four pops return 0x11, 0x22, 0x33, 0x44.
- Stop bit driven low on 0x7E → data=0x7E, framing_err=1. Back-to-back frames at fsel=1 (P=108), 0x01 then 0x80 → both received in order.
- Assert rst mid-DATA of a frame, release, then send 0x3C → count=1, data=0x3C, no stale bits, no error flags.
